// File: rtl/alu_input_ctrl_if.sv
// alu_input_ctrl_if: switch/button inputs and operand/operator outputs
// of the ALU input controller, with master (driver) and slave (controller) views.
interface alu_input_ctrl_if #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int N_OPERANDS = 2
);
    localparam int NB_SLOT = $clog2(N_OPERANDS + 1);

    logic [NB_DATA-1:0]            i_switches;
    logic                          i_btn_select;
    logic                          i_btn_set;
    logic                          i_btn_clear;
    logic [N_OPERANDS*NB_DATA-1:0] o_operands;
    logic [NB_OP-1:0]              o_operator;
    logic [NB_SLOT-1:0]            o_slot;
    logic [N_OPERANDS:0]           o_loaded;
    logic                          o_valid;

    modport master (
        output i_switches, i_btn_select, i_btn_set, i_btn_clear,
        input  o_operands, o_operator, o_slot, o_loaded, o_valid
    );

    modport slave (
        input  i_switches, i_btn_select, i_btn_set, i_btn_clear,
        output o_operands, o_operator, o_slot, o_loaded, o_valid
    );
endinterface

// File: rtl/alu_input_ctrl.sv
// alu_input_ctrl: button-driven loader of ALU operands and operator.
// Define ALU_INPUT_DEBOUNCE_EN to add per-button debounce of DB_CYCLES cycles.
module alu_input_ctrl #(
    parameter int NB_DATA    = 8,
    parameter int NB_OP      = 6,
    parameter int N_OPERANDS = 2,
    parameter int DB_CYCLES  = 1000000
) (
    input  logic          clk,
    input  logic          i_reset,
    alu_input_ctrl_if.slave bus
);
    localparam int NB_SLOT = $clog2(N_OPERANDS + 1);
    localparam int NB_LD   = N_OPERANDS + 1;
    localparam logic [NB_SLOT-1:0] SLOT_OPR = NB_SLOT'(N_OPERANDS);

    if (NB_OP < 1 || NB_OP > NB_DATA) begin : g_chk_nb_op
        $error("NB_OP must be in 1..NB_DATA");
    end
    if (N_OPERANDS < 2 || N_OPERANDS > 4) begin : g_chk_n_operands
        $error("N_OPERANDS must be in 2..4");
    end
    if (DB_CYCLES < 2) begin : g_chk_db_cycles
        $error("DB_CYCLES must be >= 2");
    end

    // bit 0 = select, bit 1 = set, bit 2 = clear
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [1:0] settle;
    logic [2:0] lvl;
    logic [2:0] lvl_d;
    logic [2:0] armed;
    logic [2:0] ev;
    logic       ev_sel;
    logic       ev_set;
    logic       ev_clr;

    assign btn_raw = {bus.i_btn_clear, bus.i_btn_set, bus.i_btn_select};

    // Two-flop synchronizer; settle marks when sync2 holds a post-reset sample
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync1  <= '0;
            sync2  <= '0;
            settle <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            settle <= {settle[0], 1'b1};
        end
    end

`ifdef ALU_INPUT_DEBOUNCE_EN
    localparam int DB_W = $clog2(DB_CYCLES);

    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      db_lvl;

    // Level follows the input only after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (i_reset) begin
            db_lvl <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] != db_lvl[i]) begin
                    if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                        db_lvl[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign lvl = db_lvl;
`else
    assign lvl = sync2;
`endif

    // Rising-edge history; a button only arms once seen released after reset
    always_ff @(posedge clk) begin
        if (i_reset) begin
            lvl_d <= '0;
            armed <= '0;
        end else begin
            lvl_d <= lvl;
            armed <= armed | ({3{settle[1]}} & ~sync2);
        end
    end

    assign ev     = lvl & ~lvl_d & armed;
    assign ev_sel = ev[0];
    assign ev_set = ev[1];
    assign ev_clr = ev[2];

    logic [NB_SLOT-1:0]            slot_q;
    logic [NB_SLOT-1:0]            slot_d;
    logic [NB_LD-1:0]              wr_en;
    logic [N_OPERANDS*NB_DATA-1:0] operands_q;
    logic [NB_OP-1:0]              operator_q;
    logic [NB_LD-1:0]              loaded_q;
    logic                          valid_q;

    // Slot state register
    always_ff @(posedge clk) begin
        if (i_reset) slot_q <= '0;
        else         slot_q <= slot_d;
    end

    // Next slot: clear returns home, select advances with wrap
    always_comb begin
        slot_d = slot_q;
        if (ev_clr) begin
            slot_d = '0;
        end else if (ev_sel) begin
            slot_d = (slot_q == SLOT_OPR) ? '0 : slot_q + 1'b1;
        end
    end

    // Slot outputs: current slot and its write strobe
    always_comb begin
        bus.o_slot = slot_q;
        wr_en      = '0;
        for (int k = 0; k < NB_LD; k++) begin
            wr_en[k] = ev_set & ~ev_clr & (slot_q == NB_SLOT'(k));
        end
    end

    // Operand/operator storage, loaded flags and the all-loaded pulse
    always_ff @(posedge clk) begin
        if (i_reset || ev_clr) begin
            operands_q <= '0;
            operator_q <= '0;
            loaded_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            for (int k = 0; k < N_OPERANDS; k++) begin
                if (wr_en[k]) operands_q[k*NB_DATA +: NB_DATA] <= bus.i_switches;
            end
            if (wr_en[N_OPERANDS]) operator_q <= bus.i_switches[NB_OP-1:0];
            loaded_q <= loaded_q | wr_en;
            valid_q  <= (|wr_en) & (&(loaded_q | wr_en));
        end
    end

    assign bus.o_operands = operands_q;
    assign bus.o_operator = operator_q;
    assign bus.o_loaded   = loaded_q;
    assign bus.o_valid    = valid_q;
endmodule

// File: tb/tb_alu_input_ctrl.sv
// tb_alu_input_ctrl: table vectors, corner sequences and a randomized
// run against a slot-level reference model of the ALU input controller.
module tb_alu_input_ctrl;
    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int N_OPS   = 2;
    localparam int DB      = 4;
`ifdef ALU_INPUT_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_input_ctrl_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .N_OPERANDS(N_OPS)) bus ();

    alu_input_ctrl #(
        .NB_DATA(NB_DATA), .NB_OP(NB_OP), .N_OPERANDS(N_OPS), .DB_CYCLES(DB)
    ) dut (
        .clk(clk),
        .i_reset(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;

    always @(negedge clk) if (bus.o_valid === 1'b1) vcnt++;

    typedef struct {
        bit         sel;
        bit         set;
        bit         clr;
        logic [7:0] sw;
        logic [7:0] e_op0;
        logic [7:0] e_op1;
        logic [5:0] e_opr;
        logic [1:0] e_slot;
        logic [2:0] e_ld;
        int         e_v;
    } vec_t;

    vec_t tbl[12];

    logic [7:0] m_op[N_OPS];
    logic [5:0] m_opr;
    int         m_slot;
    logic [2:0] m_ld;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [5:0] eo, input logic [1:0] es, input logic [2:0] el);
        check({tag, " op0"}, 64'(bus.o_operands[7:0]), 64'(e0));
        check({tag, " op1"}, 64'(bus.o_operands[15:8]), 64'(e1));
        check({tag, " opr"}, 64'(bus.o_operator), 64'(eo));
        check({tag, " slot"}, 64'(bus.o_slot), 64'(es));
        check({tag, " loaded"}, 64'(bus.o_loaded), 64'(el));
    endtask

    task automatic press(input bit sel, input bit set, input bit clr, input logic [7:0] sw);
        bus.i_switches   = sw;
        bus.i_btn_select = sel;
        bus.i_btn_set    = set;
        bus.i_btn_clear  = clr;
        tick(LAT + 1);
        bus.i_btn_select = 1'b0;
        bus.i_btn_set    = 1'b0;
        bus.i_btn_clear  = 1'b0;
        tick(LAT + 2);
    endtask

    initial begin
        int v0;
        bus.i_switches   = '0;
        bus.i_btn_select = 1'b0;
        bus.i_btn_set    = 1'b0;
        bus.i_btn_clear  = 1'b0;

        tbl[0]  = '{0, 1, 0, 8'h05, 8'h05, 8'h00, 6'h00, 2'd0, 3'b001, 0};
        tbl[1]  = '{1, 0, 0, 8'h00, 8'h05, 8'h00, 6'h00, 2'd1, 3'b001, 0};
        tbl[2]  = '{0, 1, 0, 8'hFB, 8'h05, 8'hFB, 6'h00, 2'd1, 3'b011, 0};
        tbl[3]  = '{1, 0, 0, 8'h00, 8'h05, 8'hFB, 6'h00, 2'd2, 3'b011, 0};
        tbl[4]  = '{0, 1, 0, 8'h23, 8'h05, 8'hFB, 6'h23, 2'd2, 3'b111, 1};
        tbl[5]  = '{1, 0, 0, 8'h00, 8'h05, 8'hFB, 6'h23, 2'd0, 3'b111, 0};
        tbl[6]  = '{1, 0, 0, 8'h00, 8'h05, 8'hFB, 6'h23, 2'd1, 3'b111, 0};
        tbl[7]  = '{1, 0, 0, 8'h00, 8'h05, 8'hFB, 6'h23, 2'd2, 3'b111, 0};
        tbl[8]  = '{0, 1, 0, 8'hC7, 8'h05, 8'hFB, 6'h07, 2'd2, 3'b111, 1};
        tbl[9]  = '{0, 1, 1, 8'hAA, 8'h00, 8'h00, 6'h00, 2'd0, 3'b000, 0};
        tbl[10] = '{1, 1, 0, 8'h5A, 8'h5A, 8'h00, 6'h00, 2'd1, 3'b001, 0};
        tbl[11] = '{1, 0, 1, 8'h00, 8'h00, 8'h00, 6'h00, 2'd0, 3'b000, 0};

        // reset
        rst = 1'b1;
        tick(3);
        check_state("reset", 8'h00, 8'h00, 6'h00, 2'd0, 3'b000);
        check("reset valid", 64'(bus.o_valid), 64'(0));
        rst = 1'b0;
        tick(LAT + 3);

        // table vectors
        for (int i = 0; i < 12; i++) begin
            v0 = vcnt;
            press(tbl[i].sel, tbl[i].set, tbl[i].clr, tbl[i].sw);
            check_state($sformatf("vec%0d", i), tbl[i].e_op0, tbl[i].e_op1,
                        tbl[i].e_opr, tbl[i].e_slot, tbl[i].e_ld);
            check($sformatf("vec%0d valid", i), 64'(vcnt - v0), 64'(tbl[i].e_v));
            if (i == 4) begin
                check("signed op1", 64'($signed(bus.o_operands[15:8]) == -8'sd5), 64'(1));
            end
        end

        // button held 50 cycles -> one select
        v0 = vcnt;
        bus.i_btn_select = 1'b1;
        tick(50);
        bus.i_btn_select = 1'b0;
        tick(LAT + 2);
        check("hold50 slot", 64'(bus.o_slot), 64'(1));
        check("hold50 valid", 64'(vcnt - v0), 64'(0));

        // set latency and switch sampling on the update edge
        bus.i_switches = 8'h10;
        bus.i_btn_set  = 1'b1;
        for (int j = 1; j <= LAT; j++) begin
            tick(1);
            if (j == LAT - 1) check("lat early", 64'(bus.o_loaded), 64'(0));
            if (j == LAT) begin
                check("lat loaded", 64'(bus.o_loaded), 64'(3'b010));
                check("lat sample", 64'(bus.o_operands[15:8]), 64'(8'h10 + 8'(LAT - 1)));
            end
            bus.i_switches = 8'h10 + 8'(j);
        end
        bus.i_btn_set = 1'b0;
        tick(LAT + 2);

`ifdef ALU_INPUT_DEBOUNCE_EN
        // bouncing set, then steady high
        press(0, 0, 1, 8'h00);
        bus.i_switches = 8'h77;
        for (int c = 0; c < 10; c++) begin
            bus.i_btn_set = ((c % 4) >= 2);
            tick(1);
        end
        bus.i_btn_set = 1'b0;
        tick(1);
        check("bounce none", 64'(bus.o_loaded), 64'(0));
        bus.i_btn_set = 1'b1;
        for (int j = 1; j <= DB + 3; j++) begin
            tick(1);
            if (j == DB + 2) check("db early", 64'(bus.o_loaded), 64'(0));
            if (j == DB + 3) check("db write", 64'(bus.o_loaded), 64'(3'b001));
        end
        bus.i_switches = 8'h11;
        tick(20);
        check("db once", 64'(bus.o_operands[7:0]), 64'(8'h77));
        bus.i_btn_set = 1'b0;
        tick(LAT + 2);
`endif

        // reset while set held
        bus.i_switches = 8'h99;
        bus.i_btn_set  = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(LAT + 10);
        check_state("rsthold", 8'h00, 8'h00, 6'h00, 2'd0, 3'b000);
        bus.i_btn_set = 1'b0;
        tick(LAT + 2);
        check("rsthold release", 64'(bus.o_loaded), 64'(0));
        press(0, 1, 0, 8'h99);
        check_state("rsthold repress", 8'h99, 8'h00, 6'h00, 2'd0, 3'b001);

        // randomized actions against the model
        press(0, 0, 1, 8'h00);
        m_op[0] = '0;
        m_op[1] = '0;
        m_opr   = '0;
        m_slot  = 0;
        m_ld    = '0;
        for (int it = 0; it < 40; it++) begin
            bit sel, set, clr;
            logic [7:0] sw;
            int vexp;
            clr = ($urandom_range(0, 7) == 0);
            sel = 1'($urandom_range(0, 1));
            set = 1'($urandom_range(0, 1));
            if (!sel && !set && !clr) set = 1'b1;
            sw   = 8'($urandom);
            vexp = 0;
            if (clr) begin
                m_op[0] = '0;
                m_op[1] = '0;
                m_opr   = '0;
                m_slot  = 0;
                m_ld    = '0;
            end else begin
                if (set) begin
                    if (m_slot < N_OPS) m_op[m_slot] = sw;
                    else                m_opr = sw[5:0];
                    m_ld[m_slot] = 1'b1;
                    vexp = (m_ld == 3'b111) ? 1 : 0;
                end
                if (sel) m_slot = (m_slot + 1) % (N_OPS + 1);
            end
            v0 = vcnt;
            press(sel, set, clr, sw);
            check_state($sformatf("rnd%0d", it), m_op[0], m_op[1], m_opr,
                        2'(m_slot), m_ld);
            check($sformatf("rnd%0d valid", it), 64'(vcnt - v0), 64'(vexp));
        end

        // reset from a loaded state
        press(0, 1, 0, 8'h3C);
        rst = 1'b1;
        tick(1);
        check_state("reset2", 8'h00, 8'h00, 6'h00, 2'd0, 3'b000);
        check("reset2 valid", 64'(bus.o_valid), 64'(0));
        rst = 1'b0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_input_ctrl.md
ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  NB_DATA  8  operand width, bits
  NB_OP  6  operator width, bits; 1 <= NB_OP <= NB_DATA
  N_OPERANDS  2  operand slots, range 2..4
  DB_CYCLES  1000000  debounce stability count, >= 2
REQ-002 Ports SHALL be, one per line:
  clk  input  1  clock, rising edge
  i_reset  input  1  synchronous, active-high reset
  i_switches  input  NB_DATA  raw switch value
  i_btn_select  input  1  raw button, advance slot
  i_btn_set  input  1  raw button, write switches into current slot
  i_btn_clear  input  1  raw button, clear all slots
  o_operands  output  N_OPERANDS*NB_DATA  signed operands packed; slot k at bits [k*NB_DATA +: NB_DATA]
  o_operator  output  NB_OP  operator code
  o_slot  output  $clog2(N_OPERANDS+1)  current slot: 0..N_OPERANDS-1 operands, N_OPERANDS operator
  o_loaded  output  N_OPERANDS+1  per-slot written flag; bit N_OPERANDS = operator
  o_valid  output  1  one-cycle pulse, all slots loaded

Function
REQ-003 Each button SHALL pass through a 2-flop synchronizer, then conditioning (REQ-016), then a rising-edge detector producing a one-cycle event per press.
REQ-004 Holding a button SHALL produce exactly one event; release SHALL produce none.
REQ-005 Slot FSM SHALL hold o_slot in 0..N_OPERANDS; a select event SHALL advance o_slot by 1, wrapping from N_OPERANDS to 0.
REQ-006 A set event with o_slot=k<N_OPERANDS SHALL write i_switches into operand k and set o_loaded[k].
REQ-007 A set event with o_slot=N_OPERANDS SHALL write i_switches[NB_OP-1:0] into o_operator and set o_loaded[N_OPERANDS].
REQ-008 Rewriting an already loaded slot SHALL overwrite its value; o_loaded bit stays 1.
REQ-009 i_switches SHALL be sampled on the clock edge that applies the set event; no separate switch synchronizer.
REQ-010 o_valid SHALL pulse high for exactly one cycle, the cycle after the register update in which o_loaded first becomes all-ones or in which any slot is rewritten while o_loaded is all-ones.
REQ-011 A clear event SHALL zero all operands, o_operator, o_loaded, o_slot on the next edge; o_valid SHALL not pulse.
REQ-012 Simultaneous events: clear overrides set and select; set with select SHALL write the current slot, then advance o_slot, both on the same edge.
REQ-013 Without debounce, register update SHALL occur on the 3rd clk edge after the first edge sampling the raw button high (2 sync + 1 edge stage).

Reset
REQ-014 On i_reset high at a clk edge: operands, o_operator, o_loaded, o_slot, o_valid SHALL be 0; synchronizer, debounce counters, edge-detect history SHALL be 0.
REQ-015 Reset mid-press SHALL suppress the event; a button still held after reset release SHALL NOT generate an event until released and pressed again.

Configuration
REQ-016 Macro ALU_INPUT_DEBOUNCE_EN defined: each synchronized button SHALL change its conditioned level only after differing from it for DB_CYCLES consecutive cycles; any bounce restarts the count; latency grows by DB_CYCLES cycles. Undefined: conditioned level SHALL equal synchronized level; DB_CYCLES SHALL be ignored and no counter logic SHALL exist.

Verification
REQ-017 Bench SHALL cover (N_OPERANDS=2, NB_DATA=8, NB_OP=6, macro undefined unless stated):
  - Reset, then set with switches=8'h05 -> operand0=5, o_loaded=3'b001, o_slot=0, no o_valid.
  - Set 8'h05, select, set 8'hFB, select, set 8'h23 -> operand0=5, operand1=-5, o_operator=6'h23, o_loaded=3'b111, single o_valid pulse.
  - Three selects from o_slot=2 -> o_slot sequence 0,1,2; button held 50 cycles -> exactly one event.
  - Clear and set in same cycle with all loaded -> all outputs 0, no o_valid; set+select same cycle at slot 0 -> operand0 written, o_slot=1.
  - Macro defined, DB_CYCLES=4: set pulses of 2 cycles high/2 low for 10 cycles, then steady high -> exactly one write, 4+3 cycles after steady high begins.
  - Reset asserted while set held, released with set still high -> no write until release and re-press.
